// File: rtl/sprite_pkg.sv
// sprite_pkg: shared screen defaults, colour keys, coordinate widths and pipeline latency
package sprite_pkg;
  localparam int SCR_W_DEF = 96;
  localparam int SCR_H_DEF = 64;
  localparam logic [15:0] KEY0_DEF = 16'h0000;
  localparam logic [15:0] KEY1_DEF = 16'h0001;
  localparam int X_W = 7;
  localparam int Y_W = 6;
  localparam int L_W = 5;
  localparam int IDX_W = 13;
  localparam int CMP_W = 8;
  localparam int LATENCY = 3;
  function automatic logic is_key(input logic [15:0] c, input logic [15:0] k0, input logic [15:0] k1);
    return (c == k0) || (c == k1);
  endfunction
endpackage

// File: rtl/sprite_box_test.sv
// sprite_box_test: per-sprite box hit test and local texel coordinates, compared at 8 bits so boxes never wrap
module sprite_box_test import sprite_pkg::*; #(
  parameter int SPR_W = 20,
  parameter int SPR_H = 20
) (
  input  logic           en,
  input  logic           active,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [X_W-1:0] sx,
  input  logic [Y_W-1:0] sy,
  output logic           hit,
  output logic [L_W-1:0] lx,
  output logic [L_W-1:0] ly
);
  logic [CMP_W-1:0] x8, y8, sx8, sy8;
  assign x8  = CMP_W'(x);
  assign y8  = CMP_W'(y);
  assign sx8 = CMP_W'(sx);
  assign sy8 = CMP_W'(sy);
  assign hit = en && active && (x8 >= sx8) && (x8 < sx8 + CMP_W'(SPR_W))
                            && (y8 >= sy8) && (y8 < sy8 + CMP_W'(SPR_H));
  assign lx  = hit ? L_W'(x8 - sx8) : '0;
  assign ly  = hit ? L_W'(y8 - sy8) : '0;
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: 3-cycle sprite-over-background pixel compositor; SPRITE_COLLIDE_EN adds per-frame collision flags
module sprite_compositor import sprite_pkg::*; #(
  parameter int NUM_SPR = 8,
  parameter int SPR_W = 20,
  parameter int SPR_H = 20,
  parameter int SCR_W = SCR_W_DEF,
  parameter int SCR_H = SCR_H_DEF,
  parameter logic [15:0] KEY0 = KEY0_DEF,
  parameter logic [15:0] KEY1 = KEY1_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IDX_W-1:0]       pixel_index,
  input  logic                   sample_pixel,
  input  logic                   frame_begin,
  input  logic [X_W*NUM_SPR-1:0] spr_x,
  input  logic [Y_W*NUM_SPR-1:0] spr_y,
  input  logic [NUM_SPR-1:0]     spr_active,
  output logic [L_W*NUM_SPR-1:0] fetch_x,
  output logic [L_W*NUM_SPR-1:0] fetch_y,
  output logic [NUM_SPR-1:0]     fetch_en,
  output logic [X_W-1:0]         bg_x,
  output logic [Y_W-1:0]         bg_y,
  input  logic [16*NUM_SPR-1:0]  spr_pixel,
  input  logic [15:0]            bg_pixel,
  output logic [15:0]            pixel_data,
  output logic                   pixel_valid,
  output logic [NUM_SPR-1:0]     hit_mask
);
  localparam logic [IDX_W:0] NPIX = (IDX_W+1)'(SCR_W * SCR_H);
  logic [X_W*NUM_SPR-1:0] sh_x;
  logic [Y_W*NUM_SPR-1:0] sh_y;
  logic [NUM_SPR-1:0]     sh_a;
  logic                   v1, oob1, v2, oob2;
  logic [X_W-1:0]         x1, xc;
  logic [Y_W-1:0]         y1, yc;
  logic                   in_rng;
  logic [NUM_SPR-1:0]     hit, hit2, opaque;
  logic [15:0]            colour;

  // Shadow copy of the sprite table, so a frame always sees one consistent set of positions
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_x <= '0;
      sh_y <= '0;
      sh_a <= '0;
    end else if (frame_begin) begin
      sh_x <= spr_x;
      sh_y <= spr_y;
      sh_a <= spr_active;
    end

  assign in_rng = {1'b0, pixel_index} < NPIX;
  assign xc = X_W'(pixel_index % IDX_W'(SCR_W));
  assign yc = Y_W'(pixel_index / IDX_W'(SCR_W));

  // Stage 1: split the linear index into screen x/y; off-screen requests carry no coordinates
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1   <= 1'b0;
      oob1 <= 1'b0;
      x1   <= '0;
      y1   <= '0;
    end else begin
      v1 <= sample_pixel;
      if (sample_pixel) begin
        oob1 <= !in_rng;
        x1   <= in_rng ? xc : '0;
        y1   <= in_rng ? yc : '0;
      end
    end

  assign bg_x = x1;
  assign bg_y = y1;

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_box
    sprite_box_test #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_box (
      .en     (v1 && !oob1),
      .active (sh_a[i]),
      .x      (x1),
      .y      (y1),
      .sx     (sh_x[i*X_W +: X_W]),
      .sy     (sh_y[i*Y_W +: Y_W]),
      .hit    (hit[i]),
      .lx     (fetch_x[i*L_W +: L_W]),
      .ly     (fetch_y[i*L_W +: L_W])
    );
  end

  assign fetch_en = hit;

  // Stage 2: carry hits alongside the ROM read so they line up with spr_pixel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v2   <= 1'b0;
      oob2 <= 1'b0;
      hit2 <= '0;
    end else begin
      v2   <= v1;
      oob2 <= oob1;
      hit2 <= hit;
    end

  // Priority mux: scanning from the top down leaves the lowest-index opaque sprite on top
  always_comb begin
    opaque = '0;
    colour = bg_pixel;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      opaque[i] = hit2[i] && !is_key(spr_pixel[i*16 +: 16], KEY0, KEY1);
      if (opaque[i]) colour = spr_pixel[i*16 +: 16];
    end
  end

  // Output register: one valid strobe per request, black for off-screen indices
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
    end else begin
      pixel_valid <= v2;
      if (v2) pixel_data <= oob2 ? '0 : colour;
    end

`ifdef SPRITE_COLLIDE_EN
  logic [NUM_SPR-1:0] acc;
  logic               multi;
  assign multi = |(opaque & (opaque - NUM_SPR'(1)));

  // Collision accumulator, published to hit_mask and restarted at each frame boundary
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc      <= '0;
      hit_mask <= '0;
    end else if (frame_begin) begin
      hit_mask <= acc;
      acc      <= '0;
    end else if (v2 && multi) begin
      acc <= acc | opaque;
    end
`else
  assign hit_mask = '0;
`endif
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: scoreboard bench with a ROM model and a high-level compositing reference
module tb_sprite_compositor;
  localparam int N = 8, SW = 20, SH = 20, W = 96, H = 64, LAT = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [12:0] pixel_index;
  logic sample_pixel, frame_begin;
  logic [7*N-1:0] spr_x;
  logic [6*N-1:0] spr_y;
  logic [N-1:0] spr_active, fetch_en, hit_mask;
  logic [5*N-1:0] fetch_x, fetch_y;
  logic [6:0] bg_x;
  logic [5:0] bg_y;
  logic [16*N-1:0] spr_pixel;
  logic [15:0] bg_pixel, pixel_data;
  logic pixel_valid;

  always #5 clk = ~clk;

  sprite_compositor dut (
    .clk(clk), .rst_n(rst_n), .pixel_index(pixel_index), .sample_pixel(sample_pixel),
    .frame_begin(frame_begin), .spr_x(spr_x), .spr_y(spr_y), .spr_active(spr_active),
    .fetch_x(fetch_x), .fetch_y(fetch_y), .fetch_en(fetch_en), .bg_x(bg_x), .bg_y(bg_y),
    .spr_pixel(spr_pixel), .bg_pixel(bg_pixel), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .hit_mask(hit_mask)
  );

  int in_x [N], in_y [N], sh_x [N], sh_y [N];
  bit in_a [N], sh_a [N], ovr_en [N], bg_ovr_en, done;
  logic [15:0] ovr_val [N], bg_ovr_val;
  logic [N-1:0] acc_m;
  int salt, cyc = 0, checks = 0, passes = 0;

  typedef struct { logic [15:0] data; int cyc; } pix_t;
  typedef struct { int due; logic [N-1:0] en; logic [5*N-1:0] fx, fy; logic [6:0] bx; logic [5:0] by; bit inr; } fet_t;
  typedef struct { int due; logic [N-1:0] hm; } hm_t;
  pix_t pq [$];
  fet_t fq [$];
  hm_t hq [$];
  int zq [$];

  function automatic logic [15:0] spr_rom(int i, int lx, int ly);
    int h;
    if (ovr_en[i]) return ovr_val[i];
    h = i * 7919 + lx * 131 + ly * 17 + salt;
    case (h % 4)
      0: return 16'h0000;
      1: return 16'h0001;
      default: return 16'(h * 40503) | 16'h0100;
    endcase
  endfunction

  function automatic logic [15:0] bg_rom(int x, int y);
    if (bg_ovr_en) return bg_ovr_val;
    return 16'(x * 613 + y * 97 + salt) | 16'h0002;
  endfunction

  always_comb
    for (int i = 0; i < N; i++) begin
      spr_x[i*7 +: 7]  = 7'(in_x[i]);
      spr_y[i*6 +: 6]  = 6'(in_y[i]);
      spr_active[i]    = in_a[i];
    end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++)
      spr_pixel[i*16 +: 16] <= spr_rom(i, int'(fetch_x[i*5 +: 5]), int'(fetch_y[i*5 +: 5]));
    bg_pixel <= bg_rom(int'(bg_x), int'(bg_y));
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // drive one cycle of stimulus at a negedge and record what the reference expects
  task automatic step(bit fb, bit smp, int idx);
    bit inr, found;
    int x, y;
    logic [N-1:0] hitv, opq;
    logic [5*N-1:0] fx, fy;
    logic [15:0] c, col, exp;
    frame_begin = fb;
    sample_pixel = smp;
    pixel_index = 13'(idx);
    if (fb) begin
`ifdef SPRITE_COLLIDE_EN
      hq.push_back('{cyc + 1, acc_m});
`else
      hq.push_back('{cyc + 1, {N{1'b0}}});
`endif
      acc_m = '0;
      for (int i = 0; i < N; i++) begin
        sh_x[i] = in_x[i];
        sh_y[i] = in_y[i];
        sh_a[i] = in_a[i];
      end
    end
    if (smp) begin
      inr = idx < W * H;
      x = idx % W;
      y = idx / W;
      hitv = '0; opq = '0; fx = '0; fy = '0; found = 0; col = '0;
      for (int i = 0; i < N; i++)
        if (inr && sh_a[i] && x >= sh_x[i] && x < sh_x[i] + SW && y >= sh_y[i] && y < sh_y[i] + SH) begin
          hitv[i] = 1'b1;
          fx[i*5 +: 5] = 5'(x - sh_x[i]);
          fy[i*5 +: 5] = 5'(y - sh_y[i]);
          c = spr_rom(i, x - sh_x[i], y - sh_y[i]);
          opq[i] = c != 16'h0000 && c != 16'h0001;
          if (opq[i] && !found) begin found = 1; col = c; end
        end
      exp = !inr ? 16'h0000 : found ? col : bg_rom(x, y);
      if ($countones(opq) >= 2) acc_m |= opq;
      pq.push_back('{exp, cyc});
      fq.push_back('{cyc + 1, hitv, fx, fy, 7'(x), 6'(y), inr});
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, 0);
  endtask

  task automatic clear_spr();
    for (int i = 0; i < N; i++) begin
      in_a[i] = 0; in_x[i] = 0; in_y[i] = 0; ovr_en[i] = 0;
    end
    bg_ovr_en = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      sh_a[i] = 0; sh_x[i] = 0; sh_y[i] = 0;
    end
    acc_m = '0;
  endtask

  // monitor: the only process that compares DUT outputs
  always @(negedge clk) begin
    fet_t f;
    hm_t m;
    pix_t p;
    if (zq.size() != 0 && zq[0] <= cyc) begin
      void'(zq.pop_front());
      chk("zero_valid", 64'(pixel_valid), 0);
      chk("zero_data", 64'(pixel_data), 0);
      chk("zero_fetch_en", 64'(fetch_en), 0);
      chk("zero_fetch_xy", {fetch_x, fetch_y}, 0);
      chk("zero_bg_xy", {bg_x, bg_y}, 0);
      chk("zero_hit_mask", 64'(hit_mask), 0);
    end
    if (!rst_n) begin
      pq.delete(); fq.delete(); hq.delete();
    end else begin
      if (fq.size() != 0 && fq[0].due <= cyc) begin
        f = fq.pop_front();
        chk("fetch_en", 64'(fetch_en), 64'(f.en));
        chk("fetch_x", 64'(fetch_x), 64'(f.fx));
        chk("fetch_y", 64'(fetch_y), 64'(f.fy));
        if (f.inr) chk("bg_xy", {bg_x, bg_y}, {f.bx, f.by});
      end
      if (hq.size() != 0 && hq[0].due <= cyc) begin
        m = hq.pop_front();
        chk("hit_mask", 64'(hit_mask), 64'(m.hm));
      end
      if (pixel_valid) begin
        if (pq.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          p = pq.pop_front();
          chk("pixel_data", 64'(pixel_data), 64'(p.data));
          chk("latency", 64'(cyc - p.cyc), LAT);
        end
      end else if (pq.size() != 0 && cyc - pq[0].cyc > LAT) begin
        void'(pq.pop_front());
        chk("missing_valid", 0, 1);
      end
    end
    if (done) begin
      chk("drained", 64'(pq.size() + fq.size() + hq.size()), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit l1, l2, fb, smp;
    int j, idx;
    pixel_index = '0; sample_pixel = 0; frame_begin = 0;
    clear_spr(); model_reset(); done = 0;
    salt = int'($urandom_range(0, 1000));
    @(negedge clk); @(negedge clk);
    zq.push_back(cyc + 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    // single sprite, red texel at local (0,1)
    in_x[0] = 10; in_y[0] = 10; in_a[0] = 1; ovr_en[0] = 1; ovr_val[0] = 16'hF800;
    step(1, 1, 1066); idle(4);
    // two opaque sprites overlap at (40,40): sprite 0 wins and both are flagged
    clear_spr();
    in_x[0] = 30; in_y[0] = 30; in_a[0] = 1; ovr_en[0] = 1; ovr_val[0] = 16'hF800;
    in_x[3] = 35; in_y[3] = 25; in_a[3] = 1; ovr_en[3] = 1; ovr_val[3] = 16'h001F;
    step(1, 1, 40 * 96 + 40); idle(3);
    step(1, 0, 0); idle(2);
    // transparent key over green background
    clear_spr();
    in_x[1] = 50; in_y[1] = 5; in_a[1] = 1; ovr_en[1] = 1; ovr_val[1] = 16'h0001;
    bg_ovr_en = 1; bg_ovr_val = 16'h07E0;
    step(1, 1, 10 * 96 + 55); idle(3);
    // right-edge clipping and off-screen indices
    clear_spr();
    in_x[2] = 90; in_y[2] = 30; in_a[2] = 1;
    step(1, 1, 35 * 96 + 95); step(0, 1, 35 * 96 + 2); step(0, 1, 6200); step(0, 1, 8191); idle(3);
    // mid-frame position change must not take effect yet
    in_x[2] = 0;
    step(0, 1, 35 * 96 + 95); idle(3);
    // reset one cycle after a strobe discards it
    step(0, 1, 35 * 96 + 95);
    #1 rst_n = 1'b0;
    model_reset();
    zq.push_back(cyc + 1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    // randomized traffic
    clear_spr();
    l1 = 0; l2 = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        j = int'($urandom_range(0, N - 1));
        in_x[j] = int'($urandom_range(0, 100));
        in_y[j] = int'($urandom_range(0, 55));
        in_a[j] = $urandom_range(0, 3) != 0;
      end
      fb = $urandom_range(0, 59) == 0 && !l1 && !l2;
      smp = $urandom_range(0, 3) != 0;
      idx = $urandom_range(0, 7) == 0 ? int'($urandom_range(6144, 8191)) : int'($urandom_range(0, 6143));
      step(fb, smp, idx);
      l2 = l1; l1 = smp;
    end
    idle(3);
    step(1, 0, 0);
    idle(4);
    done = 1;
  end
endmodule
